// File: rtl/mesh_term_hs_monitor.sv
// rtl/mesh_term_hs_monitor.sv - mesh terminal handshake monitor
// Per-channel watchdog, data-stability, pop-empty and post-reset idle checks with sticky flags.
module mesh_term_hs_monitor #(
  parameter int NCH     = 16,
  parameter int PCKG_SZ = 40,
  parameter int TIMEOUT = 50,
  parameter int TO_W    = 8,
  parameter int CNT_W   = 16,
  parameter int RST_WIN = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         pndng,
  input  logic [NCH-1:0]         pop,
  input  logic [NCH*PCKG_SZ-1:0] data,
  input  logic                   err_clr,
  output logic [NCH-1:0]         err_timeout,
  output logic [NCH-1:0]         err_pop_empty,
  output logic [NCH-1:0]         err_data_chg,
  output logic [NCH-1:0]         err_reset,
  output logic [NCH*CNT_W-1:0]   pkt_cnt,
  output logic                   err_any,
  output logic [$clog2(NCH)-1:0] first_err_ch,
  output logic                   first_err_vld
);

  localparam int CH_W  = $clog2(NCH);
  localparam int WIN_W = (RST_WIN > 0) ? $clog2(RST_WIN + 1) : 1;
  localparam logic [TO_W-1:0]  TO_LIM   = TO_W'(TIMEOUT);
  localparam logic [WIN_W-1:0] WIN_INIT = WIN_W'(RST_WIN);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_LATE = 2'd2;

  logic [1:0]         state_q [NCH];
  logic [1:0]         state_d [NCH];
  logic [TO_W-1:0]    wd_q    [NCH];
  logic [TO_W-1:0]    wd_d    [NCH];
  logic [PCKG_SZ-1:0] snap_q  [NCH];
  logic [PCKG_SZ-1:0] snap_d  [NCH];
  logic [CNT_W-1:0]   cnt_q   [NCH];
  logic [CNT_W-1:0]   cnt_d   [NCH];

  logic [NCH-1:0]     set_to;
  logic [NCH-1:0]     set_pe;
  logic [NCH-1:0]     set_dc;
  logic [NCH-1:0]     set_rs;
  logic [NCH-1:0]     new_err_q;
  logic [CH_W-1:0]    low_ch;
  logic [WIN_W-1:0]   win_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    set_to  = '0;
    set_pe  = '0;
    set_dc  = '0;
    set_rs  = '0;
    for (int i = 0; i < NCH; i++) begin
      set_rs[i] = (win_q != '0) &&
                  (pndng[i] || pop[i] || (|data[i*PCKG_SZ +: PCKG_SZ]));
      case (state_q[i])
        ST_IDLE: begin
          if (pndng[i] && !pop[i]) begin
            state_d[i] = ST_WAIT;
            wd_d[i]    = TO_W'(1);
            snap_d[i]  = data[i*PCKG_SZ +: PCKG_SZ];
          end else if (pndng[i] && pop[i]) begin
            cnt_d[i] = sat_inc(cnt_q[i]);
          end else if (pop[i]) begin
            set_pe[i] = 1'b1;
          end
        end
        ST_WAIT: begin
          if (pop[i]) begin
            cnt_d[i] = sat_inc(cnt_q[i]);
            // pndng still high after a pop means the next packet is already waiting
            if (pndng[i]) begin
              wd_d[i]   = TO_W'(1);
              snap_d[i] = data[i*PCKG_SZ +: PCKG_SZ];
            end else begin
              state_d[i] = ST_IDLE;
            end
          end else if (pndng[i]) begin
            if (data[i*PCKG_SZ +: PCKG_SZ] != snap_q[i]) begin
              set_dc[i] = 1'b1;
              snap_d[i] = data[i*PCKG_SZ +: PCKG_SZ];
            end
            if (wd_q[i] == TO_LIM) begin
              set_to[i]  = 1'b1;
              state_d[i] = ST_LATE;
            end else begin
              wd_d[i] = wd_q[i] + TO_W'(1);
            end
          end else begin
            state_d[i] = ST_IDLE;
          end
        end
        ST_LATE: begin
          if (pop[i]) begin
            cnt_d[i]   = sat_inc(cnt_q[i]);
            state_d[i] = ST_IDLE;
          end else if (!pndng[i]) begin
            state_d[i] = ST_IDLE;
          end else if (data[i*PCKG_SZ +: PCKG_SZ] != snap_q[i]) begin
            set_dc[i] = 1'b1;
            snap_d[i] = data[i*PCKG_SZ +: PCKG_SZ];
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    low_ch = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (new_err_q[i]) low_ch = CH_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= ST_IDLE;
        wd_q[i]    <= '0;
        snap_q[i]  <= '0;
        cnt_q[i]   <= '0;
      end
      err_timeout   <= '0;
      err_pop_empty <= '0;
      err_data_chg  <= '0;
      err_reset     <= '0;
      err_any       <= 1'b0;
      first_err_ch  <= '0;
      first_err_vld <= 1'b0;
      new_err_q     <= '0;
      win_q         <= WIN_INIT;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      // a violation in the clearing cycle survives the clear
      err_timeout   <= (err_timeout   & {NCH{~err_clr}}) | set_to;
      err_pop_empty <= (err_pop_empty & {NCH{~err_clr}}) | set_pe;
      err_data_chg  <= (err_data_chg  & {NCH{~err_clr}}) | set_dc;
      err_reset     <= (err_reset     & {NCH{~err_clr}}) | set_rs;
      new_err_q     <= set_to | set_pe | set_dc | set_rs;
      err_any       <= ~err_clr &
                       (|(err_timeout | err_pop_empty | err_data_chg | err_reset));
      if (err_clr) begin
        first_err_vld <= 1'b0;
      end else if (!first_err_vld && (|new_err_q)) begin
        first_err_vld <= 1'b1;
        first_err_ch  <= low_ch;
      end
      if (win_q != '0) win_q <= win_q - WIN_W'(1);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_cnt
    assign pkt_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_mesh_term_hs_monitor.sv
// tb/tb_mesh_term_hs_monitor.sv - self-checking bench for mesh_term_hs_monitor
// Directed handshake scenarios followed by randomized traffic against a behavioural model.
module tb_mesh_term_hs_monitor;

  localparam int NCH     = 16;
  localparam int PCKG_SZ = 40;
  localparam int TIMEOUT = 50;
  localparam int TO_W    = 8;
  localparam int CNT_W   = 16;
  localparam int RST_WIN = 4;
  localparam int CW      = 256;

  logic                   clk;
  logic                   reset;
  logic [NCH-1:0]         pndng;
  logic [NCH-1:0]         pop;
  logic [NCH*PCKG_SZ-1:0] data;
  logic                   err_clr;
  logic [NCH-1:0]         err_timeout;
  logic [NCH-1:0]         err_pop_empty;
  logic [NCH-1:0]         err_data_chg;
  logic [NCH-1:0]         err_reset;
  logic [NCH*CNT_W-1:0]   pkt_cnt;
  logic                   err_any;
  logic [$clog2(NCH)-1:0] first_err_ch;
  logic                   first_err_vld;

  mesh_term_hs_monitor #(
    .NCH(NCH), .PCKG_SZ(PCKG_SZ), .TIMEOUT(TIMEOUT),
    .TO_W(TO_W), .CNT_W(CNT_W), .RST_WIN(RST_WIN)
  ) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .pop(pop), .data(data),
    .err_clr(err_clr), .err_timeout(err_timeout), .err_pop_empty(err_pop_empty),
    .err_data_chg(err_data_chg), .err_reset(err_reset), .pkt_cnt(pkt_cnt),
    .err_any(err_any), .first_err_ch(first_err_ch), .first_err_vld(first_err_vld)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: a pending packet is tracked by its age; age past TIMEOUT means late
  bit                 m_busy [NCH];
  int                 m_age  [NCH];
  logic [PCKG_SZ-1:0] m_snap [NCH];
  int                 m_cnt  [NCH];
  bit [NCH-1:0]       m_to, m_pe, m_dc, m_rs, m_new;
  bit                 m_any, m_vld;
  int                 m_ch;
  int                 m_win;
  int                 pop_div [NCH];

  function automatic int bump(input int v);
    return (v < (1 << CNT_W) - 1) ? v + 1 : v;
  endfunction

  function automatic logic [PCKG_SZ-1:0] rnd_pkt();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[PCKG_SZ-1:0];
  endfunction

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int ch, input logic [PCKG_SZ-1:0] v);
    data[ch*PCKG_SZ +: PCKG_SZ] = v;
  endtask

  task automatic idle_inputs();
    pndng   = '0;
    pop     = '0;
    data    = '0;
    err_clr = 1'b0;
  endtask

  task automatic model_step();
    bit [NCH-1:0]       s_to, s_pe, s_dc, s_rs;
    logic [PCKG_SZ-1:0] d;
    int                 lo;
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        m_busy[i] = 1'b0; m_age[i] = 0; m_snap[i] = '0; m_cnt[i] = 0;
      end
      m_to = '0; m_pe = '0; m_dc = '0; m_rs = '0; m_new = '0;
      m_any = 1'b0; m_vld = 1'b0; m_ch = 0; m_win = RST_WIN;
      return;
    end
    s_to = '0; s_pe = '0; s_dc = '0; s_rs = '0;
    for (int i = 0; i < NCH; i++) begin
      d = data[i*PCKG_SZ +: PCKG_SZ];
      if (m_win > 0 && (pndng[i] || pop[i] || d != '0)) s_rs[i] = 1'b1;
      if (!m_busy[i]) begin
        if (pop[i] && !pndng[i]) s_pe[i] = 1'b1;
        else if (pop[i]) m_cnt[i] = bump(m_cnt[i]);
        else if (pndng[i]) begin m_busy[i] = 1'b1; m_age[i] = 1; m_snap[i] = d; end
      end else if (pop[i]) begin
        m_cnt[i] = bump(m_cnt[i]);
        if (pndng[i] && m_age[i] <= TIMEOUT) begin m_age[i] = 1; m_snap[i] = d; end
        else m_busy[i] = 1'b0;
      end else if (!pndng[i]) begin
        m_busy[i] = 1'b0;
      end else begin
        if (d !== m_snap[i]) begin s_dc[i] = 1'b1; m_snap[i] = d; end
        if (m_age[i] == TIMEOUT) s_to[i] = 1'b1;
        if (m_age[i] <= TIMEOUT) m_age[i]++;
      end
    end
    if (err_clr) m_vld = 1'b0;
    else if (!m_vld && m_new != '0) begin
      lo = 0;
      for (int i = NCH - 1; i >= 0; i--) if (m_new[i]) lo = i;
      m_vld = 1'b1;
      m_ch  = lo;
    end
    m_any = !err_clr && ((m_to | m_pe | m_dc | m_rs) != '0);
    m_new = s_to | s_pe | s_dc | s_rs;
    if (err_clr) begin m_to = '0; m_pe = '0; m_dc = '0; m_rs = '0; end
    m_to |= s_to; m_pe |= s_pe; m_dc |= s_dc; m_rs |= s_rs;
    if (m_win > 0) m_win--;
  endtask

  task automatic compare_all();
    logic [NCH*CNT_W-1:0] ec;
    for (int i = 0; i < NCH; i++) ec[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
    chk("err_timeout", err_timeout, m_to);
    chk("err_pop_empty", err_pop_empty, m_pe);
    chk("err_data_chg", err_data_chg, m_dc);
    chk("err_reset", err_reset, m_rs);
    chk("pkt_cnt", pkt_cnt, ec);
    chk("err_any", err_any, m_any);
    chk("first_err_vld", first_err_vld, m_vld);
    chk("first_err_ch", first_err_ch, m_ch);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    repeat (RST_WIN + 2) cycle();
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    cycle();
    cycle();
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) pop_div[i] = 2 + (i % 4) * 20;
    idle_inputs();
    reset = 1'b1;
    cycle();
    cycle();

    // quiet release
    reset = 1'b0;
    repeat (10) cycle();
    chk("quiet_any", err_any, 0);
    chk("quiet_cnt", pkt_cnt, 0);
    chk("quiet_vld", first_err_vld, 0);

    // pending on ch3 inside the post-reset window
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    pndng[3] = 1'b1;
    cycle();
    pndng[3] = 1'b0;
    repeat (3) cycle();
    chk("win_err_reset", err_reset, 16'h0008);
    chk("win_first_ch", first_err_ch, 3);
    chk("win_first_vld", first_err_vld, 1);
    pulse_clr();

    // ch5 popped exactly TIMEOUT cycles after pending
    pndng[5] = 1'b1;
    set_data(5, 40'h5a5a_1234_56);
    cycle();
    repeat (TIMEOUT - 1) cycle();
    pop[5] = 1'b1;
    cycle();
    pop[5] = 1'b0;
    pndng[5] = 1'b0;
    cycle();
    chk("ontime_to", err_timeout, 0);
    chk("ontime_cnt5", pkt_cnt[5*CNT_W +: CNT_W], 1);

    // ch5 popped one cycle too late
    do_reset();
    pndng[5] = 1'b1;
    set_data(5, 40'h00_dead_beef);
    cycle();
    repeat (TIMEOUT - 1) cycle();
    chk("late_pre_to", err_timeout, 0);
    cycle();
    chk("late_to", err_timeout, 16'h0020);
    pop[5] = 1'b1;
    cycle();
    pop[5] = 1'b0;
    pndng[5] = 1'b0;
    cycle();
    chk("late_cnt5", pkt_cnt[5*CNT_W +: CNT_W], 1);
    pulse_clr();

    // pop-empty on ch0 and data change on ch7 in the same cycle
    pndng[7] = 1'b1;
    set_data(7, 40'h11_2233_4455);
    cycle();
    pop[0] = 1'b1;
    set_data(7, 40'h66_7788_99aa);
    cycle();
    chk("dual_any_lag", err_any, 0);
    pop[0] = 1'b0;
    pndng[7] = 1'b0;
    cycle();
    chk("dual_pe", err_pop_empty, 16'h0001);
    chk("dual_dc", err_data_chg, 16'h0080);
    chk("dual_any", err_any, 1);
    chk("dual_first_ch", first_err_ch, 0);
    pulse_clr();

    // ch2 back-to-back pops with fresh data each cycle
    pndng[2] = 1'b1;
    set_data(2, rnd_pkt());
    cycle();
    for (int k = 0; k < 3; k++) begin
      pop[2] = 1'b1;
      set_data(2, rnd_pkt());
      cycle();
    end
    pop[2] = 1'b0;
    pndng[2] = 1'b0;
    cycle();
    chk("b2b_cnt2", pkt_cnt[2*CNT_W +: CNT_W], 3);
    chk("b2b_dc", err_data_chg, 0);

    // clear colliding with a new violation on ch1
    pop[9] = 1'b1;
    pop[12] = 1'b1;
    cycle();
    pop = '0;
    cycle();
    cycle();
    chk("pre_clr_pe", err_pop_empty, 16'h1200);
    chk("pre_clr_first", first_err_ch, 9);
    err_clr = 1'b1;
    pop[1] = 1'b1;
    cycle();
    err_clr = 1'b0;
    pop[1] = 1'b0;
    cycle();
    cycle();
    chk("clr_pe", err_pop_empty, 16'h0002);
    chk("clr_first_ch", first_err_ch, 1);
    chk("clr_first_vld", first_err_vld, 1);
    chk("clr_any", err_any, 1);

    // reset while ch4 is waiting
    idle_inputs();
    pndng[4] = 1'b1;
    set_data(4, 40'h44_4444_4444);
    repeat (10) cycle();
    idle_inputs();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    repeat (TIMEOUT + 10) cycle();
    chk("rst_mid_to", err_timeout, 0);
    chk("rst_mid_any", err_any, 0);
    chk("rst_mid_cnt", pkt_cnt, 0);
    chk("rst_mid_vld", first_err_vld, 0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      err_clr = ($urandom_range(0, 99) == 0);
      reset   = ($urandom_range(0, 1499) == 0);
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 39) == 0) pndng[i] = ~pndng[i];
        pop[i] = ($urandom_range(0, pop_div[i] - 1) == 0);
        if ($urandom_range(0, 31) == 0) set_data(i, rnd_pkt());
      end
      cycle();
    end
    idle_inputs();
    reset = 1'b0;
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mesh_term_hs_monitor.md
Name: mesh_term_hs_monitor

Overview:
- Synthesizable, parametrised handshake monitor for the mesh terminal interface (pndng/pop/data_out and pndng_i_in/popin/data_out_i_in).
- One instance watches NCH independent channels. The bench instantiates it twice per mesh: once for outbound terminals and once for inbound terminals.
- Replaces fixed 16-channel, 50-cycle assertion checks with:
  - a per-channel watchdog with programmable timeout,
  - data-stability checking,
  - pop-without-pending detection,
  - post-reset idle checking,
  - per-channel packet counters,
  - sticky error flags readable by the scoreboard.

Parameters:
- NCH, 16, number of monitored channels.
- PCKG_SZ, 40, packet width in bits.
- TIMEOUT, 50, maximum cycles from pndng rise to pop; legal range 1..2^TO_W-1.
- TO_W, 8, watchdog counter width.
- CNT_W, 16, packet counter width per channel.
- RST_WIN, 4, cycles after reset deassertion during which all channel inputs must be idle.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- pndng  in  NCH  per-channel pending flag from the producer.
- pop  in  NCH  per-channel pop strobe from the consumer.
- data  in  NCH*PCKG_SZ  per-channel packet; channel i occupies bits [i*PCKG_SZ +: PCKG_SZ].
- err_clr  in  1  one-cycle pulse; clears all sticky error flags.
- err_timeout  out  NCH  sticky; pop not seen within TIMEOUT cycles of pndng rise.
- err_pop_empty  out  NCH  sticky; pop asserted while pndng=0.
- err_data_chg  out  NCH  sticky; data changed while pending and not yet popped.
- err_reset  out  NCH  sticky; pndng, pop or data nonzero inside the post-reset window.
- pkt_cnt  out  NCH*CNT_W  per-channel count of completed pops; saturates at all-ones.
- err_any  out  1  registered OR of all sticky flags.
- first_err_ch  out  $clog2(NCH)  index of the lowest channel that raised the first error since the last clear.
- first_err_vld  out  1  first_err_ch is valid.

Behaviour:
- Reset (reset=1 at posedge):
  - all outputs go to 0;
  - every channel FSM goes to IDLE;
  - watchdogs are cleared;
  - the data snapshot is cleared;
  - the window counter is loaded with RST_WIN.
- Post-reset window:
  - The window covers the RST_WIN cycles following the first cycle in which reset=0.
  - During the window, any channel with pndng|pop|(|data) equal to 1 sets err_reset[i].
  - The window counter decrements to 0 and stops there.
  - Normal checking also runs during the window.
- Per-channel FSM states: IDLE, WAIT, LATE.
- IDLE:
  - pndng=1 & pop=0: go to WAIT, watchdog=1, snapshot=data.
  - pndng=1 & pop=1: same-cycle consume; pkt_cnt++; stay IDLE.
  - pndng=0 & pop=1: set err_pop_empty; stay IDLE.
- WAIT:
  - pop=1: pkt_cnt++. If pndng is still 1 in the same cycle, the next packet is treated as pending: watchdog=1, snapshot=data, stay in WAIT. Otherwise go to IDLE.
  - pop=0 & pndng=1:
    - data≠snapshot sets err_data_chg and updates the snapshot.
    - Watchdog increments.
    - When watchdog==TIMEOUT with no pop, set err_timeout and go to LATE.
  - pndng=0 & pop=0: producer withdrew; go to IDLE with no error.
- LATE:
  - Waits without a counter.
  - pop=1: pkt_cnt++ and go to IDLE.
  - pndng falls: go to IDLE.
  - Data-stability checking continues in this state.
- Pop at watchdog==TIMEOUT: this is on time, with no error. The timeout fires only when TIMEOUT cycles elapse with no pop, so the latest legal pop is cycle TIMEOUT after entering WAIT.
- Latency: every flag is set at the posedge that samples the violating condition and is visible one cycle later. err_any and first_err_* lag the flags by one further cycle.
- err_clr:
  - Clears all sticky flags, err_any and first_err_vld.
  - If err_clr and a new violation occur in the same cycle, the set wins.
  - err_clr does not affect FSMs, watchdogs or pkt_cnt.
- first_err_ch:
  - Latched only when first_err_vld=0 and at least one flag sets this cycle.
  - If several channels fail in the same cycle, the lowest index wins.
- pkt_cnt saturates at 2^CNT_W-1; no wrap.
- Reset asserted mid-transaction overrides everything: pending state is discarded and no error is raised for the interrupted transaction.

Test Plan:
- Post-reset checks:
  - Release reset with all inputs 0 for 10 cycles -> all outputs 0, pkt_cnt=0.
  - Drive pndng[3]=1 on the 2nd cycle after release -> err_reset[3]=1, first_err_ch=3, first_err_vld=1.
- Ch5: pndng rises; pop pulses exactly 50 cycles later -> no error; pkt_cnt[5]=1.
- Same stimulus with pop at 51 cycles -> err_timeout[5]=1 one cycle after the 50th wait cycle; pkt_cnt[5]=1 after the late pop; FSM returns to IDLE.
- Ch0 and ch7 in the same cycle:
  - pop[0] pulses with pndng[0]=0;
  - data on ch7 changes while pndng[7]=1 and unpopped;
  - -> err_pop_empty[0]=1, err_data_chg[7]=1, first_err_ch=0, err_any=1 two cycles later.
- Ch2 back-to-back traffic: pndng[2] held high with pop pulsed on 3 consecutive cycles and new data each cycle -> pkt_cnt[2]=3, no err_data_chg.
- err_clr pulse with a simultaneous new err_pop_empty[1]:
  - -> all other flags clear; err_pop_empty[1]=1; first_err_ch=1.
  - Separately, assert reset while ch4 is in WAIT -> no err_timeout[4]; all outputs 0.
